// File: rtl/wb_pkg.sv
// Shared types and constants for the write-back port arbiter.
package wb_pkg;

  localparam int unsigned XLEN   = 32;
  localparam int unsigned REG_AW = 5;

  // Write-back mux select encoding
  localparam logic WB_SEL_MEM = 1'b0;
  localparam logic WB_SEL_EX  = 1'b1;

  // One register-file write request
  typedef struct packed {
    logic [REG_AW-1:0] rd;
    logic [XLEN-1:0]   data;
  } wb_req_t;

  // True when a buffered destination collides with a decode source; x0 never hazards
  function automatic logic rd_hit(input logic [REG_AW-1:0] rd,
                                  input logic [REG_AW-1:0] rs1,
                                  input logic [REG_AW-1:0] rs2);
    return (rd != '0) && ((rd == rs1) || (rd == rs2));
  endfunction

endpackage

// File: rtl/wb_port_arbiter_if.sv
// Pipeline-side bundle of the write-back arbiter: EX/MEM offers, RF write, hazard query.
interface wb_port_arbiter_if;
  import wb_pkg::*;

  logic              EX_VALID;
  logic              EX_READY;
  logic [REG_AW-1:0] EX_RD;
  logic [XLEN-1:0]   EX_DATA;

  logic              MEM_VALID;
  logic              MEM_READY;
  logic [REG_AW-1:0] MEM_RD;
  logic [XLEN-1:0]   MEM_DATA;

  logic              WE;
  logic [REG_AW-1:0] WADDR;
  logic [XLEN-1:0]   WDATA;
  logic              CRT_WB;

  logic [REG_AW-1:0] Q_RS1;
  logic [REG_AW-1:0] Q_RS2;
  logic              HAZ;

  // Pipeline / register-file side
  modport master (
    output EX_VALID, EX_RD, EX_DATA,
    output MEM_VALID, MEM_RD, MEM_DATA,
    output Q_RS1, Q_RS2,
    input  EX_READY, MEM_READY,
    input  WE, WADDR, WDATA, CRT_WB,
    input  HAZ
  );

  // Arbiter side
  modport slave (
    input  EX_VALID, EX_RD, EX_DATA,
    input  MEM_VALID, MEM_RD, MEM_DATA,
    input  Q_RS1, Q_RS2,
    output EX_READY, MEM_READY,
    output WE, WADDR, WDATA, CRT_WB,
    output HAZ
  );

endinterface

// File: rtl/wb_ex_fifo.sv
// Synchronous FIFO of execute results; exposes per-slot rd/valid for hazard compare.
module wb_ex_fifo
  import wb_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic                                i_clk,
  input  logic                                i_rst,
  input  logic                                i_push,
  input  wb_req_t                             i_push_req,
  input  logic                                i_pop,
  output wb_req_t                             o_head,
  output logic [$clog2(DEPTH+1)-1:0]          o_count,
  output logic [DEPTH-1:0][REG_AW-1:0]        o_slot_rd,
  output logic [DEPTH-1:0]                    o_slot_vld
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH+1);

  wb_req_t            r_mem [DEPTH];
  logic [PTR_W-1:0]   r_wptr;
  logic [PTR_W-1:0]   r_rptr;
  logic [CNT_W-1:0]   r_count;
  logic [DEPTH-1:0]   r_vld;

  logic               w_full;
  logic               w_empty;
  logic               w_push;
  logic               w_pop;

  // Full blocks a push even when a pop happens in the same cycle
  assign w_full  = (r_count == CNT_W'(DEPTH));
  assign w_empty = (r_count == '0);
  assign w_push  = i_push & ~w_full;
  assign w_pop   = i_pop & ~w_empty;

  // Payload storage, no reset needed: r_vld qualifies every slot
  always_ff @(posedge i_clk) begin
    if (w_push) begin
      r_mem[r_wptr] <= i_push_req;
    end
  end

  // Pointers, occupancy count and per-slot valid bits
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
      r_vld   <= '0;
    end else begin
      if (w_push) begin
        r_wptr <= PTR_W'(r_wptr + PTR_W'(1));
      end
      if (w_pop) begin
        r_rptr <= PTR_W'(r_rptr + PTR_W'(1));
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= CNT_W'(r_count + CNT_W'(1));
        2'b01:   r_count <= CNT_W'(r_count - CNT_W'(1));
        default: r_count <= r_count;
      endcase
      for (int unsigned i = 0; i < DEPTH; i++) begin
        if (w_push && (r_wptr == PTR_W'(i))) begin
          r_vld[i] <= 1'b1;
        end else if (w_pop && (r_rptr == PTR_W'(i))) begin
          r_vld[i] <= 1'b0;
        end
      end
    end
  end

  // Slot rd view for the hazard comparator
  always_comb begin
    o_slot_rd = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      o_slot_rd[i] = r_mem[i].rd;
    end
  end

  assign o_head     = r_mem[r_rptr];
  assign o_count    = r_count;
  assign o_slot_vld = r_vld;

endmodule

// File: rtl/wb_port_arbiter.sv
// Shares the register-file write port between buffered EX results and MEM load data.
module wb_port_arbiter
  import wb_pkg::*;
#(
  parameter int unsigned EX_DEPTH = 2,
  parameter int unsigned MAX_WAIT = 3
) (
  input  logic              CLK,
  input  logic              RST,
  wb_port_arbiter_if.slave  bus
);

  localparam int unsigned CNT_W = $clog2(EX_DEPTH+1);
  localparam int unsigned SC_W  = $clog2(MAX_WAIT+1);

  wb_req_t                       w_head;
  wb_req_t                       w_push_req;
  wb_req_t                       w_win_req;
  logic [CNT_W-1:0]              w_count;
  logic [EX_DEPTH-1:0][REG_AW-1:0] w_slot_rd;
  logic [EX_DEPTH-1:0]           w_slot_vld;

  logic                          w_ex_ready;
  logic                          w_push;
  logic                          w_fifo_ne;
  logic                          w_force_ex;
  logic                          w_mem_win;
  logic                          w_ex_win;
  logic                          w_grant;
  logic                          w_win_sel;
  logic                          w_haz;

  logic [SC_W-1:0]               r_starve;
  logic                          r_we;
  logic [REG_AW-1:0]             r_waddr;
  logic [XLEN-1:0]               r_wdata;
  logic                          r_crt_wb;

  assign w_push_req = '{rd: bus.EX_RD, data: bus.EX_DATA};
  assign w_ex_ready = (w_count < CNT_W'(EX_DEPTH));
  assign w_push     = bus.EX_VALID & w_ex_ready;

  wb_ex_fifo #(
    .DEPTH (EX_DEPTH)
  ) u_ex_fifo (
    .i_clk      (CLK),
    .i_rst      (RST),
    .i_push     (w_push),
    .i_push_req (w_push_req),
    .i_pop      (w_ex_win),
    .o_head     (w_head),
    .o_count    (w_count),
    .o_slot_rd  (w_slot_rd),
    .o_slot_vld (w_slot_vld)
  );

  // Arbitration: MEM by default, EX forced once it has lost MAX_WAIT times in a row
  assign w_fifo_ne  = (w_count != '0);
  assign w_force_ex = w_fifo_ne && (r_starve == SC_W'(MAX_WAIT));
  assign w_mem_win  = bus.MEM_VALID & ~w_force_ex;
  assign w_ex_win   = w_fifo_ne & ~w_mem_win;

  // Select the winning request and its mux code
  always_comb begin
    w_grant   = 1'b0;
    w_win_req = '0;
    w_win_sel = WB_SEL_MEM;
    if (w_mem_win) begin
      w_grant   = 1'b1;
      w_win_req = '{rd: bus.MEM_RD, data: bus.MEM_DATA};
      w_win_sel = WB_SEL_MEM;
    end else if (w_ex_win) begin
      w_grant   = 1'b1;
      w_win_req = w_head;
      w_win_sel = WB_SEL_EX;
    end
  end

  // Starvation counter: counts consecutive MEM wins over a waiting EX head
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_starve <= '0;
    end else if (!w_fifo_ne || w_ex_win) begin
      r_starve <= '0;
    end else if (w_mem_win && (r_starve != SC_W'(MAX_WAIT))) begin
      r_starve <= SC_W'(r_starve + SC_W'(1));
    end
  end

  // Registered write port; x0 writes are consumed but never enabled
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_we     <= 1'b0;
      r_waddr  <= '0;
      r_wdata  <= '0;
      r_crt_wb <= WB_SEL_MEM;
    end else begin
      r_we <= w_grant && (w_win_req.rd != '0);
      if (w_grant) begin
        r_waddr  <= w_win_req.rd;
        r_wdata  <= w_win_req.data;
        r_crt_wb <= w_win_sel;
      end
    end
  end

  // RAW hazard against every occupied FIFO slot, pre-edge view
  always_comb begin
    w_haz = 1'b0;
    for (int unsigned i = 0; i < EX_DEPTH; i++) begin
      if (w_slot_vld[i] && rd_hit(w_slot_rd[i], bus.Q_RS1, bus.Q_RS2)) begin
        w_haz = 1'b1;
      end
    end
  end

  assign bus.EX_READY  = w_ex_ready;
  assign bus.MEM_READY = ~w_force_ex;
  assign bus.WE        = r_we;
  assign bus.WADDR     = r_waddr;
  assign bus.WDATA     = r_wdata;
  assign bus.CRT_WB    = r_crt_wb;
  assign bus.HAZ       = w_haz;

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Directed bench for wb_port_arbiter with a write scoreboard checked on every WE.
module tb_wb_port_arbiter;
  import wb_pkg::*;

  typedef struct packed {
    logic [REG_AW-1:0] addr;
    logic [XLEN-1:0]   data;
    logic              sel;
  } exp_t;

  logic        CLK = 1'b0;
  logic        RST;
  int unsigned n_checks = 0;
  int unsigned n_errs   = 0;
  exp_t        sb[$];
  exp_t        mon_e;

  wb_port_arbiter_if u_if ();

  wb_port_arbiter #(
    .EX_DEPTH (2),
    .MAX_WAIT (3)
  ) u_dut (
    .CLK (CLK),
    .RST (RST),
    .bus (u_if)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errs++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge CLK);
    #1;
  endtask

  task automatic smp();
    @(negedge CLK);
  endtask

  task automatic drv(input int unsigned ev, input int unsigned erd, input int unsigned ed,
                     input int unsigned mv, input int unsigned mrd, input int unsigned md);
    u_if.EX_VALID  = 1'(ev);
    u_if.EX_RD     = REG_AW'(erd);
    u_if.EX_DATA   = XLEN'(ed);
    u_if.MEM_VALID = 1'(mv);
    u_if.MEM_RD    = REG_AW'(mrd);
    u_if.MEM_DATA  = XLEN'(md);
  endtask

  task automatic expect_wr(input int unsigned a, input int unsigned d, input int unsigned s);
    exp_t e;
    e.addr = REG_AW'(a);
    e.data = XLEN'(d);
    e.sel  = 1'(s);
    sb.push_back(e);
  endtask

  task automatic drain();
    for (int i = 0; i < 20 && sb.size() != 0; i++) begin
      cyc();
      smp();
    end
    chk("sb_drain", 32'(sb.size()), 32'd0);
  endtask

  // Every enabled write must match the oldest outstanding expectation
  always @(negedge CLK) begin
    if (u_if.WE === 1'b1) begin
      if (sb.size() == 0) begin
        chk("unexpected_we", 32'(u_if.WE), 32'd0);
      end else begin
        mon_e = sb.pop_front();
        chk("wr_addr", 32'(u_if.WADDR), 32'(mon_e.addr));
        chk("wr_data", u_if.WDATA, mon_e.data);
        chk("wr_sel", 32'(u_if.CRT_WB), 32'(mon_e.sel));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    u_if.Q_RS1 = 5'd0;
    u_if.Q_RS2 = 5'd0;
    drv(0, 0, 0, 0, 0, 0);
    RST = 1'b1;
    cyc();
    cyc();
    smp();
    chk("rst_we", 32'(u_if.WE), 32'd0);
    chk("rst_waddr", 32'(u_if.WADDR), 32'd0);
    chk("rst_wdata", u_if.WDATA, 32'd0);
    chk("rst_crt", 32'(u_if.CRT_WB), 32'd0);
    chk("rst_ex_ready", 32'(u_if.EX_READY), 32'd1);
    chk("rst_mem_ready", 32'(u_if.MEM_READY), 32'd1);
    chk("rst_haz", 32'(u_if.HAZ), 32'd0);
    RST = 1'b0;

    // EX only: push in cycle 1, write visible in cycle 3
    cyc();
    drv(1, 5, 'hAA, 0, 0, 0);
    expect_wr(5, 'hAA, 1);
    smp();
    chk("t1_ex_ready_c1", 32'(u_if.EX_READY), 32'd1);
    cyc();
    drv(0, 0, 0, 0, 0, 0);
    smp();
    chk("t1_no_bypass_we", 32'(u_if.WE), 32'd0);
    chk("t1_ex_ready_c2", 32'(u_if.EX_READY), 32'd1);
    cyc();
    smp();
    chk("t1_we_c3", 32'(u_if.WE), 32'd1);
    chk("t1_crt_c3", 32'(u_if.CRT_WB), 32'd1);
    cyc();
    smp();
    chk("t1_we_clear", 32'(u_if.WE), 32'd0);
    drain();

    // Collision: MEM overtakes the buffered EX result
    cyc();
    drv(1, 3, 'h11, 0, 0, 0);
    smp();
    cyc();
    drv(0, 0, 0, 1, 4, 'h22);
    expect_wr(4, 'h22, 0);
    expect_wr(3, 'h11, 1);
    smp();
    chk("t2_mem_ready", 32'(u_if.MEM_READY), 32'd1);
    cyc();
    drv(0, 0, 0, 0, 0, 0);
    smp();
    chk("t2_c3_waddr", 32'(u_if.WADDR), 32'd4);
    chk("t2_c3_crt", 32'(u_if.CRT_WB), 32'd0);
    cyc();
    smp();
    chk("t2_c4_waddr", 32'(u_if.WADDR), 32'd3);
    chk("t2_c4_crt", 32'(u_if.CRT_WB), 32'd1);
    drain();

    // Starvation: three MEM wins, then EX forced with MEM_READY low
    cyc();
    drv(1, 7, 'h77, 0, 0, 0);
    smp();
    for (int i = 0; i < 3; i++) begin
      cyc();
      drv(0, 0, 0, 1, 10 + i, 'h100 + i);
      expect_wr(10 + i, 'h100 + i, 0);
      smp();
      chk("t3_mem_ready_pre", 32'(u_if.MEM_READY), 32'd1);
    end
    cyc();
    drv(0, 0, 0, 1, 13, 'h103);
    expect_wr(7, 'h77, 1);
    expect_wr(13, 'h103, 0);
    smp();
    chk("t3_forced_mem_ready", 32'(u_if.MEM_READY), 32'd0);
    cyc();
    smp();
    chk("t3_mem_ready_after", 32'(u_if.MEM_READY), 32'd1);
    chk("t3_ex_waddr", 32'(u_if.WADDR), 32'd7);
    chk("t3_ex_crt", 32'(u_if.CRT_WB), 32'd1);
    cyc();
    drv(0, 0, 0, 0, 0, 0);
    smp();
    chk("t3_held_mem_waddr", 32'(u_if.WADDR), 32'd13);
    drain();

    // Full FIFO: rd=9 push is refused and never written
    cyc();
    drv(1, 1, 'hE1, 1, 20, 'h2020);
    expect_wr(20, 'h2020, 0);
    smp();
    cyc();
    drv(1, 2, 'hE2, 1, 21, 'h2021);
    expect_wr(21, 'h2021, 0);
    smp();
    cyc();
    drv(1, 9, 'h99, 1, 22, 'h2022);
    expect_wr(22, 'h2022, 0);
    smp();
    chk("t4_full_ex_ready", 32'(u_if.EX_READY), 32'd0);
    cyc();
    drv(0, 0, 0, 1, 23, 'h2023);
    expect_wr(23, 'h2023, 0);
    smp();
    chk("t4_still_full", 32'(u_if.EX_READY), 32'd0);
    chk("t4_mem_ready_w2", 32'(u_if.MEM_READY), 32'd1);
    cyc();
    drv(0, 0, 0, 1, 24, 'h2024);
    expect_wr(1, 'hE1, 1);
    expect_wr(24, 'h2024, 0);
    smp();
    chk("t4_forced_mem_ready", 32'(u_if.MEM_READY), 32'd0);
    cyc();
    smp();
    chk("t4_ex_ready_after_pop", 32'(u_if.EX_READY), 32'd1);
    cyc();
    drv(0, 0, 0, 0, 0, 0);
    expect_wr(2, 'hE2, 1);
    smp();
    drain();

    // x0 load: accepted, no write enable
    cyc();
    drv(0, 0, 0, 1, 0, 'hFFFF_FFFF);
    smp();
    chk("t5_x0_mem_ready", 32'(u_if.MEM_READY), 32'd1);
    cyc();
    drv(0, 0, 0, 0, 0, 0);
    smp();
    chk("t5_x0_we", 32'(u_if.WE), 32'd0);

    // Hazard against a buffered rd=6, including the cycle it is popped
    cyc();
    drv(1, 6, 'h66, 1, 0, 0);
    smp();
    cyc();
    drv(0, 0, 0, 1, 0, 0);
    u_if.Q_RS1 = 5'd0;
    u_if.Q_RS2 = 5'd6;
    smp();
    chk("t5_haz_rs2", 32'(u_if.HAZ), 32'd1);
    chk("t5_x0_we_hold", 32'(u_if.WE), 32'd0);
    cyc();
    u_if.Q_RS2 = 5'd0;
    smp();
    chk("t5_haz_rs1_zero", 32'(u_if.HAZ), 32'd0);
    cyc();
    drv(0, 0, 0, 0, 0, 0);
    u_if.Q_RS1 = 5'd6;
    expect_wr(6, 'h66, 1);
    smp();
    chk("t5_haz_pop_cycle", 32'(u_if.HAZ), 32'd1);
    cyc();
    smp();
    chk("t5_haz_after_pop", 32'(u_if.HAZ), 32'd0);
    u_if.Q_RS1 = 5'd0;
    drain();

    // Reset with two buffered entries discards them
    cyc();
    drv(1, 1, 'hA1, 1, 0, 0);
    smp();
    cyc();
    drv(1, 2, 'hA2, 1, 0, 0);
    smp();
    cyc();
    drv(0, 0, 0, 1, 0, 0);
    RST = 1'b1;
    u_if.Q_RS1 = 5'd1;
    u_if.Q_RS2 = 5'd2;
    smp();
    chk("t6_pre_rst_full", 32'(u_if.EX_READY), 32'd0);
    chk("t6_pre_rst_haz", 32'(u_if.HAZ), 32'd1);
    cyc();
    RST = 1'b0;
    drv(0, 0, 0, 0, 0, 0);
    smp();
    chk("t6_we", 32'(u_if.WE), 32'd0);
    chk("t6_ex_ready", 32'(u_if.EX_READY), 32'd1);
    chk("t6_mem_ready", 32'(u_if.MEM_READY), 32'd1);
    chk("t6_haz", 32'(u_if.HAZ), 32'd0);
    for (int i = 0; i < 6; i++) begin
      cyc();
      smp();
      chk("t6_no_stale_we", 32'(u_if.WE), 32'd0);
      chk("t6_no_stale_haz", 32'(u_if.HAZ), 32'd0);
    end
    chk("sb_final_empty", 32'(sb.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule
